chan_mux_pipe: RTL

Registered N-channel, W-bit multiplexer with valid/ready handshaking on every input and on the output. It replaces bare 1-bit select muxes wherever the systolic datapath must steer whole operand words from several producers into one processing-element port. Channels are selected either explicitly by a select input or, optionally, by a fair round-robin arbiter. One output register gives a single-cycle latency and sustains one transfer per cycle.

---
 rtl/chan_mux_pipe_if.sv | 27 ++
 rtl/chan_mux_pipe.sv | 130 +++++++++++++
 2 files changed

// File: rtl/chan_mux_pipe_if.sv
// Handshake bundle for chan_mux_pipe: N input channels, explicit select/mode
// controls, and one registered output channel with its source index.
interface chan_mux_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEL_W-1:0]        out_ch;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_valid, out_ch
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/chan_mux_pipe.sv
// Registered N-channel valid/ready word multiplexer, single-cycle latency.
// Define MUX_RR_EN to compile in the round-robin arbiter selected by mode=1.
module chan_mux_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  chan_mux_pipe_if.slave bus
);
  localparam logic [SEL_W:0]   NCH_L     = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH_L = SEL_W'(NUM_CH-1);

  logic              accept_s;
  logic              rr_mode_s;
  logic              rr_vld_s;
  logic [SEL_W-1:0]  rr_ch_s;
  logic              grant_vld_s;
  logic [SEL_W-1:0]  grant_ch_s;
  logic [NUM_CH-1:0] in_ready_s;
  logic [WIDTH-1:0]  grant_data_s;
  logic              xfer_s;
  logic [WIDTH-1:0]  out_data_r;
  logic [SEL_W-1:0]  out_ch_r;
  logic              out_valid_r;

  assign accept_s = !out_valid_r || bus.out_ready;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W:0]   idx_s;

  assign rr_mode_s = bus.mode;

  // Round-robin search from ptr; scanning downward lets the nearest valid channel win.
  always_comb begin
    rr_vld_s = 1'b0;
    rr_ch_s  = '0;
    idx_s    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx_s = {1'b0, ptr_r} + (SEL_W+1)'(i);
      if (idx_s >= NCH_L) begin
        idx_s = idx_s - NCH_L;
      end else begin
        idx_s = idx_s;
      end
      if (bus.in_valid[idx_s[SEL_W-1:0]]) begin
        rr_vld_s = 1'b1;
        rr_ch_s  = idx_s[SEL_W-1:0];
      end else begin
        rr_vld_s = rr_vld_s;
      end
    end
  end

  // Pointer moves just past the channel that won a round-robin transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (xfer_s && rr_mode_s) begin
      ptr_r <= (grant_ch_s == LAST_CH_L) ? '0 : grant_ch_s + SEL_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  logic unused_mode_s;

  assign unused_mode_s = bus.mode;
  assign rr_mode_s     = 1'b0;
  assign rr_vld_s      = 1'b0;
  assign rr_ch_s       = '0;
`endif

  // Pick the granted channel; an out-of-range explicit select grants nobody.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_ch_s  = '0;
    if (rr_mode_s) begin
      grant_vld_s = rr_vld_s;
      grant_ch_s  = rr_ch_s;
    end else begin
      grant_vld_s = ({1'b0, bus.sel} < NCH_L);
      grant_ch_s  = bus.sel;
    end
  end

  // One-hot ready toward the granted channel and its data word.
  always_comb begin
    in_ready_s   = '0;
    grant_data_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_ch_s == SEL_W'(k)) begin
        in_ready_s[k] = grant_vld_s && accept_s;
        grant_data_s  = bus.in_data[k*WIDTH +: WIDTH];
      end else begin
        in_ready_s[k] = 1'b0;
      end
    end
  end

  assign xfer_s = |(in_ready_s & bus.in_valid);

  // Output register: load on transfer, drop valid when consumed, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= grant_data_s;
      out_ch_r    <= grant_ch_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_ch_r    <= out_ch_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_ch_r    <= out_ch_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_ch    = out_ch_r;
endmodule
